adder_share_ctrl: RTL and testbench

- Round-robin scheduler that shares one sequential_adder instance among N_REQ requesters.
- Accepts operand requests over valid/ready handshakes and issues a one-cycle start to the adder.
- Waits for the adder's done, captures sum/carry, and returns the result tagged with the requester id on one response channel.
- A watchdog bounds the wait so that a non-terminating adder cannot hang the system.

---
 rtl/adder_share_pkg.sv | 16 +
 rtl/rr_arbiter.sv | 31 +++
 rtl/adder_share_ctrl.sv | 119 +++++++++++
 tb/tb_adder_share_ctrl.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/adder_share_pkg.sv
// Shared types and defaults for the round-robin adder-sharing controller.
package adder_share_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    // A ripple/sequential adder needs about 2*SIZE cycles; two spare cycles of margin.
    function automatic int default_timeout(input int size);
        return 2 * size + 2;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or above ptr, with wrap.
module rr_arbiter #(
    parameter int N_REQ = 4,
    localparam int ID_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    input  logic             en,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  grant_idx
);

    int   idx;
    logic found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(ptr) + k) % N_REQ;
            if (en && !found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/adder_share_ctrl.sv
// Time-shares one sequential adder among N_REQ requesters with round-robin grant,
// a one-cycle start pulse, watchdog-bounded wait and a single tagged response channel.
module adder_share_ctrl
    import adder_share_pkg::*;
#(
    parameter int SIZE    = 8,
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = default_timeout(SIZE),
    localparam int ID_W   = $clog2(N_REQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [N_REQ*SIZE-1:0] req_a,
    input  logic [N_REQ*SIZE-1:0] req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ID_W-1:0]       rsp_id,
    output logic [SIZE-1:0]       rsp_sum,
    output logic                  rsp_carry,
    output logic                  rsp_err,
    output logic                  adder_start,
    output logic [SIZE-1:0]       adder_a,
    output logic [SIZE-1:0]       adder_b,
    input  logic [SIZE-1:0]       adder_sum,
    input  logic                  adder_carry,
    input  logic                  adder_done,
    output logic                  busy
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t            state, state_next;
    logic [ID_W-1:0]   ptr, grant_idx, id_q;
    logic [N_REQ-1:0]  grant;
    logic              arb_en, timeout_hit;
    logic [SIZE-1:0]   a_q, b_q, sum_q;
    logic              carry_q, err_q;
    logic [CNT_W-1:0]  cnt;

    // Gating with rst keeps req_ready low while reset is held, even though state is IDLE.
    assign arb_en      = (state == IDLE) && !rst;
    assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req       (req_valid),
        .ptr       (ptr),
        .en        (arb_en),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (|grant) state_next = ISSUE;
            ISSUE: state_next = WAIT;
            WAIT:  if (adder_done || timeout_hit) state_next = RESP;
            RESP:  if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr     <= '0;
            id_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            err_q   <= 1'b0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE: if (|grant) begin
                    a_q  <= req_a[int'(grant_idx)*SIZE +: SIZE];
                    b_q  <= req_b[int'(grant_idx)*SIZE +: SIZE];
                    id_q <= grant_idx;
                    ptr  <= (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
                end
                ISSUE: cnt <= '0;
                // The adder keeps iterating past done, so only the first done cycle is valid.
                WAIT: begin
                    if (adder_done) begin
                        sum_q   <= adder_sum;
                        carry_q <= adder_carry;
                        err_q   <= 1'b0;
                    end else if (timeout_hit) begin
                        sum_q   <= adder_sum;
                        carry_q <= adder_carry;
                        err_q   <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready   = grant;
    assign adder_start = (state == ISSUE);
    assign adder_a     = a_q;
    assign adder_b     = b_q;
    assign rsp_valid   = (state == RESP);
    assign rsp_id      = id_q;
    assign rsp_sum     = sum_q;
    assign rsp_carry   = carry_q;
    assign rsp_err     = err_q;
    assign busy        = (state != IDLE);

endmodule

// File: tb/tb_adder_share_ctrl.sv
// Directed bench: the bench plays the shared adder cycle by cycle and checks grant order,
// latency, backpressure, timeout, stale-done rejection and asynchronous reset.
module tb_adder_share_ctrl;

    localparam int SIZE    = 8;
    localparam int N_REQ   = 4;
    localparam int TIMEOUT = 18;

    logic                  clk, rst;
    logic [N_REQ-1:0]      req_valid, req_ready;
    logic [N_REQ*SIZE-1:0] req_a, req_b;
    logic                  rsp_valid, rsp_ready;
    logic [1:0]            rsp_id;
    logic [SIZE-1:0]       rsp_sum, adder_a, adder_b, adder_sum;
    logic                  rsp_carry, rsp_err, adder_start, adder_carry, adder_done, busy;

    logic [7:0] a_tab   [4] = '{8'h31, 8'h12, 8'hF0, 8'h7E};
    logic [7:0] b_tab   [4] = '{8'h05, 8'h00, 8'h20, 8'h83};
    logic [7:0] sum_tab [4] = '{8'h36, 8'h12, 8'h10, 8'h01};
    logic       cy_tab  [4] = '{1'b0, 1'b0, 1'b1, 1'b1};

    int errs = 0, checks = 0, cyc = 0, gcyc = 0, prev = 0;

    assign req_a = {a_tab[3], a_tab[2], a_tab[1], a_tab[0]};
    assign req_b = {b_tab[3], b_tab[2], b_tab[1], b_tab[0]};

    adder_share_ctrl #(.SIZE(SIZE), .N_REQ(N_REQ), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_sum(rsp_sum), .rsp_carry(rsp_carry), .rsp_err(rsp_err),
        .adder_start(adder_start), .adder_a(adder_a), .adder_b(adder_b),
        .adder_sum(adder_sum), .adder_carry(adder_carry), .adder_done(adder_done),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    // Runs one transaction starting in an IDLE cycle; done_at < 0 means the adder never finishes.
    task automatic txn(input int id, input int done_at, input int bp, input bit drop, input bit stale);
        logic [7:0] es;
        logic       ec, ee, last;
        if (done_at < 0) begin es = 8'hD1; ec = 1'b1; ee = 1'b1; end
        else begin es = sum_tab[id]; ec = cy_tab[id]; ee = 1'b0; end
        rsp_ready  = 1'b0;
        adder_done = stale;
        adder_sum  = 8'hEE;
        adder_carry = 1'b1;
        #1;
        chk("grant", 32'(req_ready), 32'(1 << id));
        chk("busy_idle", 32'(busy), 0);
        gcyc = cyc;
        step();
        if (drop) req_valid[id] = 1'b0;
        #1;
        chk("start_issue", 32'(adder_start), 1);
        chk("adder_a", 32'(adder_a), 32'(a_tab[id]));
        chk("adder_b", 32'(adder_b), 32'(b_tab[id]));
        chk("ready_issue", 32'(req_ready), 0);
        step();
        for (int w = 0; w < TIMEOUT; w++) begin
            last        = (w == done_at) || (done_at < 0 && w == TIMEOUT - 1);
            adder_done  = (w == done_at);
            adder_sum   = last ? es : 8'(8'hC0 + w);
            adder_carry = last ? ec : 1'b1;
            #1;
            chk("start_wait", 32'(adder_start), 0);
            chk("valid_wait", 32'(rsp_valid), 0);
            step();
            if (last) break;
        end
        adder_done  = 1'b0;
        adder_sum   = 8'h5A;
        adder_carry = 1'b0;
        chk("latency", 32'(cyc - gcyc), 32'(done_at < 0 ? 2 + TIMEOUT : 3 + done_at));
        for (int k = 0; k <= bp; k++) begin
            rsp_ready = (k == bp);
            #1;
            chk("rsp_valid", 32'(rsp_valid), 1);
            chk("rsp_id", 32'(rsp_id), 32'(id));
            chk("rsp_sum", 32'(rsp_sum), 32'(es));
            chk("rsp_carry", 32'(rsp_carry), 32'(ec));
            chk("rsp_err", 32'(rsp_err), 32'(ee));
            chk("ready_resp", 32'(req_ready), 0);
            chk("start_resp", 32'(adder_start), 0);
            step();
        end
        rsp_ready = 1'b0;
        chk("back_idle", 32'(busy), 0);
        chk("valid_idle", 32'(rsp_valid), 0);
    endtask

    initial begin
        rst = 1'b1; req_valid = '0; rsp_ready = 1'b0;
        adder_done = 1'b1; adder_sum = 8'h77; adder_carry = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_valid", 32'(rsp_valid), 0);
        chk("rst_start", 32'(adder_start), 0);
        chk("rst_ready", 32'(req_ready), 0);
        chk("rst_sum", 32'(rsp_sum), 0);
        chk("rst_a", 32'(adder_a), 0);
        @(negedge clk);
        rst = 1'b0;

        // single requester, done in first WAIT cycle
        req_valid = 4'b0010;
        txn(1, 0, 0, 1'b1, 1'b0);
        // move the pointer back to 0
        req_valid = 4'b1000;
        txn(3, 1, 0, 1'b1, 1'b0);

        // all requesters active: fair rotation and minimum spacing
        req_valid = 4'b1111;
        for (int j = 0; j < 5; j++) begin
            prev = gcyc;
            txn(j % 4, 2, 0, 1'b0, 1'b0);
            if (j > 0) chk("grant_gap", 32'(gcyc - prev), 6);
        end

        // backpressure with other requesters still pending
        txn(1, 1, 5, 1'b0, 1'b0);

        // watchdog, then a normal completion
        req_valid = 4'b0100;
        txn(2, -1, 0, 1'b1, 1'b0);
        req_valid = 4'b1000;
        txn(3, 0, 0, 1'b1, 1'b0);

        // stale done before WAIT must not be captured
        req_valid = 4'b0001;
        txn(0, 2, 0, 1'b1, 1'b1);

        // async reset in the middle of WAIT
        req_valid = 4'b0100;
        #1;
        chk("pre_rst_grant", 32'(req_ready), 32'h4);
        step();
        req_valid = 4'b0000;
        step();
        chk("pre_rst_busy", 32'(busy), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_busy", 32'(busy), 0);
        chk("arst_valid", 32'(rsp_valid), 0);
        chk("arst_start", 32'(adder_start), 0);
        chk("arst_a", 32'(adder_a), 0);
        req_valid = 4'b1010;
        #1;
        chk("arst_ready", 32'(req_ready), 0);
        @(negedge clk);
        rst = 1'b0;
        txn(1, 0, 0, 1'b1, 1'b0);
        txn(3, 1, 0, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
